// File: rtl/ins_loader.sv
// Operator-side instruction-memory writer: builds 32-bit words from switch bytes on
// button edges and strobes each committed word into memory at an auto-incrementing address.
module ins_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        SW_BYTE,
  input  logic              LOAD,
  input  logic              COMMIT,
  input  logic              CLEAR,
  output logic [31:0]       W_Ins,
  output logic              WE,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [2:0]        ByteCnt,
  output logic              FULL,
  output logic              ERR
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);
  localparam logic [2:0]        WORD_BYTES = 3'd4;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_READY   = 2'd1,
    S_WRITE   = 2'd2,
    S_FULL    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       ins_q, ins_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic              we_q, we_d;

  // Button edge detection; events are registered together with the switch byte they capture.
  logic       load_prev_q, commit_prev_q, clear_prev_q;
  logic       load_ev_q, commit_ev_q, clear_ev_q;
  logic [7:0] sw_q;

  always_ff @(posedge CLK) begin
    load_prev_q   <= LOAD;
    commit_prev_q <= COMMIT;
    clear_prev_q  <= CLEAR;
    if (RST) begin
      load_ev_q   <= 1'b0;
      commit_ev_q <= 1'b0;
      clear_ev_q  <= 1'b0;
      sw_q        <= 8'd0;
    end else begin
      load_ev_q   <= LOAD & ~load_prev_q;
      commit_ev_q <= COMMIT & ~commit_prev_q;
      clear_ev_q  <= CLEAR & ~clear_prev_q;
      sw_q        <= SW_BYTE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_COLLECT;
      ins_q   <= 32'd0;
      addr_q  <= '0;
      cnt_q   <= 3'd0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ins_q   <= ins_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      err_q   <= err_d;
      we_q    <= we_d;
    end
  end

  // Next-state logic; CLEAR overrides everything, COMMIT beats LOAD.
  always_comb begin
    state_d = state_q;
    ins_d   = ins_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    err_d   = err_q;
    we_d    = 1'b0;
    if (clear_ev_q) begin
      state_d = S_COLLECT;
      ins_d   = 32'd0;
      addr_d  = '0;
      cnt_d   = 3'd0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_COLLECT: begin
          if (commit_ev_q) begin
            err_d = 1'b1;
          end else if (load_ev_q) begin
            ins_d = {ins_q[23:0], sw_q};
            cnt_d = cnt_q + 3'd1;
            err_d = 1'b0;
            if (cnt_q == WORD_BYTES - 3'd1) state_d = S_READY;
          end
        end
        S_READY: begin
          if (commit_ev_q) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
          end
        end
        S_WRITE: begin
          ins_d = 32'd0;
          cnt_d = 3'd0;
          if (addr_q == LAST_ADDR) begin
            full_d  = 1'b1;
            state_d = S_FULL;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_COLLECT;
          end
        end
        S_FULL: begin
          state_d = S_FULL;
        end
        default: begin
          state_d = S_COLLECT;
        end
      endcase
    end
  end

  assign W_Ins   = ins_q;
  assign WE      = we_q;
  assign W_Addr  = addr_q;
  assign ByteCnt = cnt_q;
  assign FULL    = full_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_ins_loader.sv
// Bench for ins_loader: directed literal cases plus randomized button traffic checked
// every cycle against a byte-queue model of the loader.
module tb_ins_loader;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned MAX_WORDS = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [7:0]        SW_BYTE = 8'd0;
  logic              LOAD = 1'b0;
  logic              COMMIT = 1'b0;
  logic              CLEAR = 1'b0;
  logic [31:0]       W_Ins;
  logic              WE;
  logic [ADDR_W-1:0] W_Addr;
  logic [2:0]        ByteCnt;
  logic              FULL;
  logic              ERR;

  ins_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .CLK(CLK), .RST(RST), .SW_BYTE(SW_BYTE), .LOAD(LOAD), .COMMIT(COMMIT), .CLEAR(CLEAR),
    .W_Ins(W_Ins), .WE(WE), .W_Addr(W_Addr), .ByteCnt(ByteCnt), .FULL(FULL), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: the current word is a queue of captured bytes.
  logic [7:0] m_q[$];
  int         m_addr;
  bit         m_full, m_err, m_wr;
  bit         m_pl, m_pc, m_px;
  bit         m_el, m_ec, m_ex;
  logic [7:0] m_sw;

  function automatic logic [31:0] m_word();
    logic [31:0] r;
    r = 32'd0;
    foreach (m_q[i]) r = (r << 8) | 32'(m_q[i]);
    return r;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_q.delete();
      m_addr = 0; m_full = 0; m_err = 0; m_wr = 0;
      m_el = 0; m_ec = 0; m_ex = 0; m_sw = 8'd0;
    end else begin
      if (m_wr) begin
        m_wr = 0;
        m_q.delete();
        if (m_ex) begin
          m_addr = 0; m_full = 0; m_err = 0;
        end else if (m_addr == int'(MAX_WORDS) - 1) m_full = 1;
        else m_addr++;
      end else if (m_ex) begin
        m_q.delete();
        m_addr = 0; m_full = 0; m_err = 0;
      end else if (m_full) begin
        m_err = m_err;
      end else if (m_ec) begin
        if (m_q.size() == 4) m_wr = 1;
        else m_err = 1;
      end else if (m_el && m_q.size() < 4) begin
        m_q.push_back(m_sw);
        m_err = 0;
      end
      m_el = LOAD & ~m_pl;
      m_ec = COMMIT & ~m_pc;
      m_ex = CLEAR & ~m_px;
      m_sw = SW_BYTE;
    end
    m_pl = LOAD; m_pc = COMMIT; m_px = CLEAR;
  end

  // Whole-output comparison against the model on every cycle.
  always @(negedge CLK) begin
    if (chk_en)
      check("model", {18'd0, W_Ins, WE, W_Addr, ByteCnt, FULL, ERR},
            {18'd0, m_word(), m_wr, ADDR_W'(m_addr), 3'(m_q.size()), m_full, m_err});
  end

  int         we_cnt = 0;
  logic [31:0] we_ins;
  logic [7:0]  we_addr;
  always @(negedge CLK) begin
    if (WE) begin
      we_cnt++;
      we_ins  = W_Ins;
      we_addr = W_Addr;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  // which: 0 = LOAD, 1 = COMMIT, 2 = CLEAR
  task automatic press(input int which, input logic [7:0] b);
    @(negedge CLK);
    SW_BYTE = b;
    if (which == 0) LOAD = 1'b1;
    else if (which == 1) COMMIT = 1'b1;
    else CLEAR = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0; COMMIT = 1'b0; CLEAR = 1'b0;
    idle(2);
  endtask

  task automatic load_word(input logic [31:0] w);
    press(0, w[31:24]); press(0, w[23:16]); press(0, w[15:8]); press(0, w[7:0]);
  endtask

  int w0, lat;
  bit found;

  initial begin
    idle(3);
    @(negedge CLK);
    RST = 1'b0;
    chk_en = 1'b1;
    check("reset_state", {18'd0, W_Ins, WE, W_Addr, ByteCnt, FULL, ERR}, 64'd0);

    // 1: basic word and commit latency
    press(0, 8'h20); press(0, 8'h08); press(0, 8'h00); press(0, 8'h05);
    check("t1_word", 64'(W_Ins), 64'h20080005);
    w0 = we_cnt; found = 0; lat = 0;
    @(negedge CLK);
    COMMIT = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      if (i == 1) COMMIT = 1'b0;
      if (WE && !found) begin found = 1; lat = i; end
    end
    check("t1_latency", 64'(lat), 64'd2);
    check("t1_we_count", 64'(we_cnt - w0), 64'd1);
    check("t1_we_ins", 64'(we_ins), 64'h20080005);
    check("t1_we_addr", 64'(we_addr), 64'd0);
    check("t1_addr_after", 64'(W_Addr), 64'd1);
    check("t1_cnt_after", 64'(ByteCnt), 64'd0);

    // 2: incomplete commit raises ERR, next LOAD clears it
    press(2, 8'h00);
    press(0, 8'hA1); press(0, 8'hB2);
    w0 = we_cnt;
    press(1, 8'h00);
    check("t2_err", 64'(ERR), 64'd1);
    check("t2_cnt", 64'(ByteCnt), 64'd2);
    check("t2_no_we", 64'(we_cnt - w0), 64'd0);
    press(0, 8'hC3);
    check("t2_err_clr", 64'(ERR), 64'd0);
    check("t2_cnt3", 64'(ByteCnt), 64'd3);

    // 3: fifth byte ignored
    press(2, 8'h00);
    load_word(32'h11223344);
    press(0, 8'hFF);
    check("t3_word", 64'(W_Ins), 64'h11223344);
    check("t3_cnt", 64'(ByteCnt), 64'd4);

    // 4: fill to MAX_WORDS
    press(2, 8'h00);
    w0 = we_cnt;
    for (int k = 0; k < 4; k++) begin
      load_word(32'hC0DE0000 + 32'(k));
      press(1, 8'h00);
      check("t4_addr", 64'(we_addr), 64'(k));
      check("t4_ins", 64'(we_ins), 64'hC0DE0000 + 64'(k));
    end
    check("t4_we_count", 64'(we_cnt - w0), 64'd4);
    check("t4_full", 64'(FULL), 64'd1);
    check("t4_addr_hold", 64'(W_Addr), 64'd3);
    w0 = we_cnt;
    load_word(32'h01020304);
    press(1, 8'h00);
    check("t4_no_we_full", 64'(we_cnt - w0), 64'd0);
    press(2, 8'h00);
    check("t4_clr_full", 64'(FULL), 64'd0);
    check("t4_clr_addr", 64'(W_Addr), 64'd0);

    // 5: CLEAR and COMMIT together, then LOAD held through reset
    load_word(32'hAABBCCDD); press(1, 8'h00);
    load_word(32'h55667788);
    w0 = we_cnt;
    @(negedge CLK);
    COMMIT = 1'b1; CLEAR = 1'b1;
    @(negedge CLK);
    COMMIT = 1'b0; CLEAR = 1'b0;
    idle(4);
    check("t5_no_we", 64'(we_cnt - w0), 64'd0);
    check("t5_zero", {18'd0, W_Ins, WE, W_Addr, ByteCnt, FULL, ERR}, 64'd0);
    @(negedge CLK);
    LOAD = 1'b1; SW_BYTE = 8'h5A; RST = 1'b1;
    idle(2);
    RST = 1'b0;
    idle(3);
    LOAD = 1'b0;
    idle(2);
    check("t5_held_load", 64'(ByteCnt), 64'd0);

    // 6: reset right after a COMMIT edge
    load_word(32'h0BADF00D);
    w0 = we_cnt;
    @(negedge CLK);
    COMMIT = 1'b1;
    @(negedge CLK);
    COMMIT = 1'b0; RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("t6_reset_vals", {18'd0, W_Ins, WE, W_Addr, ByteCnt, FULL, ERR}, 64'd0);
    idle(4);
    check("t6_no_we", 64'(we_cnt - w0), 64'd0);

    // Random button traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      RST     = ($urandom_range(0, 299) == 0);
      SW_BYTE = 8'($urandom);
      LOAD    = ($urandom_range(0, 2) == 0);
      COMMIT  = ($urandom_range(0, 5) == 0);
      CLEAR   = ($urandom_range(0, 59) == 0);
    end
    @(negedge CLK);
    RST = 1'b0; LOAD = 1'b0; COMMIT = 1'b0; CLEAR = 1'b0;
    idle(3);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
